// File: rtl/com_gesture_detector.sv
// Turns the per-frame centre-of-mass stream into game controls: it calibrates a
// standing baseline height, then emits jump/duck pulses and lane-change pulses.
module com_gesture_detector #(
  parameter int CAL_FRAMES      = 8,
  parameter int LANE_LEFT_X     = 427,
  parameter int LANE_RIGHT_X    = 853,
  parameter int HYST            = 16,
  parameter int JUMP_DY         = 40,
  parameter int DUCK_DY         = 40,
  parameter int COOLDOWN_FRAMES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] com_x,
  input  logic [9:0]  com_y,
  input  logic        com_valid,
  input  logic        recal,
  output logic        calibrated,
  output logic [9:0]  baseline_y,
  output logic [1:0]  lane,
  output logic        jump,
  output logic        duck,
  output logic        move_left,
  output logic        move_right
);

  localparam int CAL_SHIFT = $clog2(CAL_FRAMES);
  localparam int SUM_W     = 10 + CAL_SHIFT;
  localparam int CD_W      = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [11:0] LEFT_OUT  = 12'(LANE_LEFT_X - HYST);
  localparam logic [11:0] LEFT_IN   = 12'(LANE_LEFT_X + HYST);
  localparam logic [11:0] RIGHT_OUT = 12'(LANE_RIGHT_X + HYST);
  localparam logic [11:0] RIGHT_IN  = 12'(LANE_RIGHT_X - HYST);
  localparam logic [10:0] JUMP_D    = 11'(JUMP_DY);
  localparam logic [10:0] DUCK_D    = 11'(DUCK_DY);
  localparam logic [CD_W-1:0]      CD_LOAD  = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CAL_SHIFT-1:0] CNT_LAST = CAL_SHIFT'(CAL_FRAMES - 1);

  typedef enum logic [1:0] {CALIBRATE, TRACK, COOLDOWN} state_t;

  state_t               state;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     sum_next;
  logic [CAL_SHIFT-1:0] cnt;
  logic [CD_W-1:0]      cd;

  logic [11:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] base_ext;
  logic        is_jump;
  logic        is_duck;
  logic [1:0]  lane_next;
  logic        step_left;
  logic        step_right;

  // Vertical thresholds are compared one bit wider than the inputs so the offsets never wrap.
  assign x_ext    = {1'b0, com_x};
  assign y_ext    = {1'b0, com_y};
  assign base_ext = {1'b0, baseline_y};
  assign is_jump  = (y_ext + JUMP_D) < base_ext;
  assign is_duck  = y_ext > (base_ext + DUCK_D);
  assign sum_next = sum + {{CAL_SHIFT{1'b0}}, com_y};

  always_comb begin
    lane_next  = lane;
    step_left  = 1'b0;
    step_right = 1'b0;
    case (lane)
      2'd0: begin
        if (x_ext >= LEFT_IN) begin
          lane_next  = 2'd1;
          step_right = 1'b1;
        end
      end
      2'd1: begin
        if (x_ext < LEFT_OUT) begin
          lane_next = 2'd0;
          step_left = 1'b1;
        end else if (x_ext > RIGHT_OUT) begin
          lane_next  = 2'd2;
          step_right = 1'b1;
        end
      end
      2'd2: begin
        if (x_ext <= RIGHT_IN) begin
          lane_next = 2'd1;
          step_left = 1'b1;
        end
      end
      default: lane_next = 2'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CALIBRATE;
      sum        <= '0;
      cnt        <= '0;
      cd         <= '0;
      calibrated <= 1'b0;
      baseline_y <= '0;
      lane       <= 2'd1;
      jump       <= 1'b0;
      duck       <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      jump       <= 1'b0;
      duck       <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      // recal takes priority and discards any sample arriving alongside it.
      if (recal) begin
        state      <= CALIBRATE;
        sum        <= '0;
        cnt        <= '0;
        cd         <= '0;
        calibrated <= 1'b0;
        lane       <= 2'd1;
      end else if (com_valid) begin
        case (state)
          CALIBRATE: begin
            if (cnt == CNT_LAST) begin
              baseline_y <= sum_next[SUM_W-1:CAL_SHIFT];
              calibrated <= 1'b1;
              state      <= TRACK;
              sum        <= '0;
              cnt        <= '0;
            end else begin
              sum <= sum_next;
              cnt <= cnt + CAL_SHIFT'(1);
            end
          end
          TRACK: begin
            jump <= is_jump;
            duck <= is_duck;
            if ((is_jump || is_duck) && (COOLDOWN_FRAMES > 0)) begin
              cd    <= CD_LOAD;
              state <= COOLDOWN;
            end
          end
          COOLDOWN: begin
            cd <= cd - CD_W'(1);
            if (cd <= CD_W'(1)) state <= TRACK;
          end
          default: state <= CALIBRATE;
        endcase
        if (state != CALIBRATE) begin
          lane       <= lane_next;
          move_left  <= step_left;
          move_right <= step_right;
        end
      end
    end
  end

endmodule

// File: tb/tb_com_gesture_detector.sv
// Scoreboard bench for com_gesture_detector: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them one cycle after each sample.
module tb_com_gesture_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] com_x;
  logic [9:0]  com_y;
  logic        com_valid;
  logic        recal;
  logic        calibrated;
  logic [9:0]  baseline_y;
  logic [1:0]  lane;
  logic        jump;
  logic        duck;
  logic        move_left;
  logic        move_right;

  com_gesture_detector dut (
    .clk(clk), .rst(rst), .com_x(com_x), .com_y(com_y), .com_valid(com_valid),
    .recal(recal), .calibrated(calibrated), .baseline_y(baseline_y), .lane(lane),
    .jump(jump), .duck(duck), .move_left(move_left), .move_right(move_right)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_JUMP = 4'b1000;
  localparam logic [3:0] P_DUCK = 4'b0100;
  localparam logic [3:0] P_ML   = 4'b0010;
  localparam logic [3:0] P_MR   = 4'b0001;

  typedef struct {
    string      name;
    logic [3:0] pulses;
    logic [1:0] lane;
    logic       cal;
    logic [9:0] base;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic evt_d = 1'b0;
  bit   done = 1'b0;
  bit   drain_checked = 1'b0;

  task automatic push_exp(input string name, input logic [3:0] p, input int ln,
                          input bit cal, input int base);
    exp_t e;
    e.name   = name;
    e.pulses = p;
    e.lane   = 2'(ln);
    e.cal    = cal;
    e.base   = 10'(base);
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(input int n);
    com_valid = 1'b0;
    recal     = 1'b0;
    rst       = 1'b1;
    repeat (n) begin
      push_exp("reset", P_NONE, 1, 1'b0, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Drives one com_valid cycle; consecutive calls give back-to-back samples.
  task automatic apply_stimulus(input string name, input int x, input int y, input bit rc,
                                input logic [3:0] p, input int ln, input bit cal, input int base);
    com_x     = 11'(x);
    com_y     = 10'(y);
    recal     = rc;
    com_valid = 1'b1;
    push_exp(name, p, ln, cal, base);
    @(posedge clk);
    #1;
    com_valid = 1'b0;
    recal     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input exp_t e);
    vectors++;
    if ({jump, duck, move_left, move_right, lane, calibrated, baseline_y} !==
        {e.pulses, e.lane, e.cal, e.base}) begin
      miscompares++;
      $display("[TB] FAIL %s: got jdlr=%b lane=%0d cal=%b base=%0d, expected jdlr=%b lane=%0d cal=%b base=%0d",
               e.name, {jump, duck, move_left, move_right}, lane, calibrated, baseline_y,
               e.pulses, e.lane, e.cal, e.base);
    end
  endtask

  always @(posedge clk) evt_d <= com_valid | rst;

  always @(negedge clk) begin
    if (evt_d) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_event: got output with empty scoreboard, expected none");
      end else begin
        check_output(exp_q.pop_front());
      end
    end else if (!done) begin
      vectors++;
      if ({jump, duck, move_left, move_right} !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL idle_pulse: got jdlr=%b, expected 0000",
                 {jump, duck, move_left, move_right});
      end
    end
    if (done && !drain_checked) begin
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      drain_checked = 1'b1;
    end
  end

  initial begin
    int cal_y[8] = '{400, 401, 399, 400, 402, 398, 400, 400};
    com_x = 11'd640;
    com_y = 10'd400;
    apply_reset(2);

    for (int i = 0; i < 7; i++) apply_stimulus("cal_sample", 640, cal_y[i], 1'b0, P_NONE, 1, 1'b0, 0);
    apply_stimulus("cal_done", 640, cal_y[7], 1'b0, P_NONE, 1, 1'b1, 400);
    idle(2);

    apply_stimulus("jump_edge_360", 640, 360, 1'b0, P_NONE, 1, 1'b1, 400);
    apply_stimulus("jump_359", 640, 359, 1'b0, P_JUMP, 1, 1'b1, 400);
    for (int i = 0; i < 6; i++) apply_stimulus("cooldown_drain", 640, 400, 1'b0, P_NONE, 1, 1'b1, 400);

    apply_stimulus("duck_441", 640, 441, 1'b0, P_DUCK, 1, 1'b1, 400);
    idle(1);
    for (int i = 0; i < 6; i++) apply_stimulus("cooldown_no_jump", 640, 300, 1'b0, P_NONE, 1, 1'b1, 400);
    apply_stimulus("jump_after_cooldown", 640, 300, 1'b0, P_JUMP, 1, 1'b1, 400);
    for (int i = 0; i < 6; i++) apply_stimulus("cooldown_drain2", 640, 400, 1'b0, P_NONE, 1, 1'b1, 400);

    apply_stimulus("lane_420", 420, 400, 1'b0, P_NONE, 1, 1'b1, 400);
    apply_stimulus("lane_410", 410, 400, 1'b0, P_ML, 0, 1'b1, 400);
    apply_stimulus("lane_440", 440, 400, 1'b0, P_NONE, 0, 1'b1, 400);
    apply_stimulus("lane_443", 443, 400, 1'b0, P_MR, 1, 1'b1, 400);
    apply_stimulus("lane_400", 400, 400, 1'b0, P_ML, 0, 1'b1, 400);
    apply_stimulus("swing_900_a", 900, 400, 1'b0, P_MR, 1, 1'b1, 400);
    apply_stimulus("swing_900_b", 900, 400, 1'b0, P_MR, 2, 1'b1, 400);
    apply_stimulus("right_838", 838, 400, 1'b0, P_NONE, 2, 1'b1, 400);
    apply_stimulus("right_837", 837, 400, 1'b0, P_ML, 1, 1'b1, 400);
    apply_stimulus("centre_869", 869, 400, 1'b0, P_NONE, 1, 1'b1, 400);
    apply_stimulus("centre_870", 870, 400, 1'b0, P_MR, 2, 1'b1, 400);
    apply_stimulus("right_837_b", 837, 400, 1'b0, P_ML, 1, 1'b1, 400);
    apply_stimulus("centre_411", 411, 400, 1'b0, P_NONE, 1, 1'b1, 400);

    apply_stimulus("combo_left_jump", 410, 359, 1'b0, P_ML | P_JUMP, 0, 1'b1, 400);
    apply_stimulus("cooldown_lane", 443, 300, 1'b0, P_MR, 1, 1'b1, 400);

    apply_stimulus("recal_collision", 900, 300, 1'b1, P_NONE, 1, 1'b0, 400);
    for (int i = 0; i < 7; i++) apply_stimulus("recal_sample", 100, 500, 1'b0, P_NONE, 1, 1'b0, 400);
    apply_stimulus("recal_done", 100, 500, 1'b0, P_NONE, 1, 1'b1, 500);
    idle(1);
    apply_stimulus("duck_edge_540", 640, 540, 1'b0, P_NONE, 1, 1'b1, 500);
    apply_stimulus("duck_541", 640, 541, 1'b0, P_DUCK, 1, 1'b1, 500);
    apply_stimulus("cooldown_left", 100, 100, 1'b0, P_ML, 0, 1'b1, 500);

    apply_reset(1);
    apply_stimulus("post_reset_sample", 100, 200, 1'b0, P_NONE, 1, 1'b0, 0);
    idle(4);

    done = 1'b1;
    repeat (4) begin
      if (!drain_checked) @(posedge clk);
    end
    if (!drain_checked) $display("[TB] FAIL drain_timeout: got no drain check, expected one");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
